// File: rtl/otter_cu_fsm_pkg.sv
// Shared definitions for the Otter multicycle control unit.
// Holds the RV32I major opcodes, the PC source select codes, the MRET
// immediate, the FSM state encoding and the control-output bundle type.
package otter_cu_fsm_pkg;

  // RV32I major opcodes (ir[6:0])
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // PC source mux codes
  localparam logic [2:0] PC_SEL_NEXT   = 3'd0;
  localparam logic [2:0] PC_SEL_JALR   = 3'd1;
  localparam logic [2:0] PC_SEL_BRANCH = 3'd2;
  localparam logic [2:0] PC_SEL_JAL    = 3'd3;
  localparam logic [2:0] PC_SEL_MTVEC  = 3'd4;
  localparam logic [2:0] PC_SEL_MEPC   = 3'd5;

  // ir[31:20] of MRET
  localparam logic [11:0] MRET_IMM = 12'h302;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WB    = 3'd3,
    ST_TRAP  = 3'd4
  } state_e;

  // Control outputs produced by the FSM each cycle
  typedef struct packed {
    logic       pc_w_en;
    logic [2:0] pc_src_sel;
    logic       imem_rd;
    logic       ir_ld;
    logic       dmem_rd;
    logic       dmem_wr;
    logic       rf_we;
    logic       csr_we;
    logic       int_taken;
    logic       mret_exec;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/otter_cu_fsm_if.sv
// Control-unit <-> datapath signal bundle.
//   master : the control FSM (drives enables, reads ir/flags/handshakes)
//   slave  : the datapath/memory side (drives ir/flags/handshakes)
// Inputs to the FSM : ir, br_eq, br_lt, br_ltu, intr, mie, imem_ready, dmem_ready
// Outputs of the FSM: pc_w_en, pc_src_sel, imem_rd, ir_ld, dmem_rd, dmem_wr,
//                     rf_we, csr_we, int_taken, mret_exec, illegal
interface otter_cu_fsm_if;
  logic [31:0] ir;
  logic        br_eq;
  logic        br_lt;
  logic        br_ltu;
  logic        intr;
  logic        mie;
  logic        imem_ready;
  logic        dmem_ready;

  logic        pc_w_en;
  logic [2:0]  pc_src_sel;
  logic        imem_rd;
  logic        ir_ld;
  logic        dmem_rd;
  logic        dmem_wr;
  logic        rf_we;
  logic        csr_we;
  logic        int_taken;
  logic        mret_exec;
  logic        illegal;

  modport master (
    input  ir, br_eq, br_lt, br_ltu, intr, mie, imem_ready, dmem_ready,
    output pc_w_en, pc_src_sel, imem_rd, ir_ld, dmem_rd, dmem_wr,
           rf_we, csr_we, int_taken, mret_exec, illegal
  );

  modport slave (
    output ir, br_eq, br_lt, br_ltu, intr, mie, imem_ready, dmem_ready,
    input  pc_w_en, pc_src_sel, imem_rd, ir_ld, dmem_rd, dmem_wr,
           rf_we, csr_we, int_taken, mret_exec, illegal
  );
endinterface

// File: rtl/otter_cu_fsm_branch_cond_gen.sv
// Branch condition generator (combinational).
// Ports:
//   funct3_i  in  3  branch funct3 field
//   br_eq_i   in  1  rs1 == rs2
//   br_lt_i   in  1  rs1 <  rs2 signed
//   br_ltu_i  in  1  rs1 <  rs2 unsigned
//   taken_o   out 1  branch taken
//   valid_o   out 1  funct3 encodes a defined branch (010/011 do not)
module branch_cond_gen (
  input  logic [2:0] funct3_i,
  input  logic       br_eq_i,
  input  logic       br_lt_i,
  input  logic       br_ltu_i,
  output logic       taken_o,
  output logic       valid_o
);

  // Map funct3 onto the comparison flags
  always_comb begin
    taken_o = 1'b0;
    valid_o = 1'b1;
    case (funct3_i)
      3'b000:  taken_o = br_eq_i;     // BEQ
      3'b001:  taken_o = ~br_eq_i;    // BNE
      3'b100:  taken_o = br_lt_i;     // BLT
      3'b101:  taken_o = ~br_lt_i;    // BGE
      3'b110:  taken_o = br_ltu_i;    // BLTU
      3'b111:  taken_o = ~br_ltu_i;   // BGEU
      default: begin                  // 010/011 unsupported
        taken_o = 1'b0;
        valid_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/otter_cu_fsm.sv
// Otter RV32I multicycle control FSM.
// Sequences INIT -> FETCH -> EXEC [-> WB] [-> TRAP] -> FETCH, producing the
// PC/RF/CSR/memory enables from the current state, ir and handshake inputs.
// Ports:
//   clk   in  clock
//   rst   in  synchronous active-high reset (forces INIT, outputs held 0)
//   cu    master modport of otter_cu_fsm_if (see interface file for members)
// Parameter:
//   INIT_CYCLES  cycles spent in INIT before the first fetch (>=1)
module otter_cu_fsm
  import otter_cu_fsm_pkg::*;
#(
  parameter int INIT_CYCLES = 4
) (
  input logic            clk,
  input logic            rst,
  otter_cu_fsm_if.master cu
);

  localparam int CNT_W = $clog2(INIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] init_cnt_q, init_cnt_d;
  ctrl_t            ctrl_s;
  ctrl_t            ctrl_out_s;
  logic             retire_s;
  logic [2:0]       ret_sel_s;
  logic             br_taken_s;
  logic             br_valid_s;

  logic [6:0]       opcode_s;
  logic [2:0]       funct3_s;
  logic [11:0]      imm12_s;
  logic             unused_ir_s;

  assign opcode_s    = cu.ir[6:0];
  assign funct3_s    = cu.ir[14:12];
  assign imm12_s     = cu.ir[31:20];
  assign unused_ir_s = ^{cu.ir[19:15], cu.ir[11:7]};

  branch_cond_gen u_branch_cond (
    .funct3_i (funct3_s),
    .br_eq_i  (cu.br_eq),
    .br_lt_i  (cu.br_lt),
    .br_ltu_i (cu.br_ltu),
    .taken_o  (br_taken_s),
    .valid_o  (br_valid_s)
  );

  // State register and INIT counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // Next-state and control decode
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    ctrl_s     = '0;
    retire_s   = 1'b0;
    ret_sel_s  = PC_SEL_NEXT;

    case (state_q)
      ST_INIT: begin
        if (init_cnt_q == INIT_LAST) begin
          state_d    = ST_FETCH;
          init_cnt_d = '0;
        end else begin
          init_cnt_d = init_cnt_q + 1'b1;
        end
      end

      ST_FETCH: begin
        ctrl_s.imem_rd = 1'b1;
        if (cu.imem_ready) begin
          ctrl_s.ir_ld = 1'b1;
          state_d      = ST_EXEC;
        end else begin
          state_d      = ST_FETCH;
        end
      end

      ST_EXEC: begin
        case (opcode_s)
          OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: begin
            ctrl_s.rf_we = 1'b1;
            retire_s     = 1'b1;
          end
          OPC_JAL: begin
            ctrl_s.rf_we = 1'b1;
            retire_s     = 1'b1;
            ret_sel_s    = PC_SEL_JAL;
          end
          OPC_JALR: begin
            ctrl_s.rf_we = 1'b1;
            retire_s     = 1'b1;
            ret_sel_s    = PC_SEL_JALR;
          end
          OPC_BRANCH: begin
            retire_s       = 1'b1;
            ret_sel_s      = br_taken_s ? PC_SEL_BRANCH : PC_SEL_NEXT;
            ctrl_s.illegal = ~br_valid_s;
          end
          OPC_STORE: begin
            // Stay in EXEC with the request held until memory acknowledges
            ctrl_s.dmem_wr = 1'b1;
            if (cu.dmem_ready) begin
              retire_s = 1'b1;
            end else begin
              retire_s = 1'b0;
            end
          end
          OPC_LOAD: begin
            // PC update is deferred to WB so rd is written before retiring
            ctrl_s.dmem_rd = 1'b1;
            if (cu.dmem_ready) begin
              state_d = ST_WB;
            end else begin
              state_d = ST_EXEC;
            end
          end
          OPC_SYSTEM: begin
            retire_s = 1'b1;
            if (funct3_s != 3'b000) begin
              ctrl_s.csr_we = 1'b1;
              ctrl_s.rf_we  = 1'b1;
            end else if (imm12_s == MRET_IMM) begin
              ctrl_s.mret_exec = 1'b1;
              ret_sel_s        = PC_SEL_MEPC;
            end else begin
              ctrl_s.illegal = 1'b1;   // ECALL/EBREAK etc. retire as NOP
            end
          end
          default: begin
            ctrl_s.illegal = 1'b1;
            retire_s       = 1'b1;
          end
        endcase
      end

      ST_WB: begin
        ctrl_s.rf_we = 1'b1;
        retire_s     = 1'b1;
      end

      ST_TRAP: begin
        ctrl_s.pc_w_en    = 1'b1;
        ctrl_s.pc_src_sel = PC_SEL_MTVEC;
        ctrl_s.int_taken  = 1'b1;
        state_d           = ST_FETCH;
      end

      default: begin
        state_d    = ST_INIT;
        init_cnt_d = '0;
      end
    endcase

    // Retirement: the single point where an instruction updates the PC and
    // where a pending enabled interrupt is recognised.
    if (retire_s) begin
      ctrl_s.pc_w_en    = 1'b1;
      ctrl_s.pc_src_sel = ret_sel_s;
      state_d           = (cu.intr && cu.mie) ? ST_TRAP : ST_FETCH;
    end else begin
      ctrl_s.pc_w_en = ctrl_s.pc_w_en;
    end
  end

  // Reset masks every output in the cycle it is asserted
  assign ctrl_out_s = rst ? '0 : ctrl_s;

  assign cu.pc_w_en    = ctrl_out_s.pc_w_en;
  assign cu.pc_src_sel = ctrl_out_s.pc_src_sel;
  assign cu.imem_rd    = ctrl_out_s.imem_rd;
  assign cu.ir_ld      = ctrl_out_s.ir_ld;
  assign cu.dmem_rd    = ctrl_out_s.dmem_rd;
  assign cu.dmem_wr    = ctrl_out_s.dmem_wr;
  assign cu.rf_we      = ctrl_out_s.rf_we;
  assign cu.csr_we     = ctrl_out_s.csr_we;
  assign cu.int_taken  = ctrl_out_s.int_taken;
  assign cu.mret_exec  = ctrl_out_s.mret_exec;
  assign cu.illegal    = ctrl_out_s.illegal;

endmodule

// File: tb/tb_otter_cu_fsm.sv
// Self-checking bench for otter_cu_fsm: directed vector table, hand-written
// multi-cycle sequences and randomized instructions against a behavioural model.
module tb_otter_cu_fsm;

  // Output vector layout: {pc_w_en, sel[2:0], imem_rd, ir_ld, dmem_rd, dmem_wr,
  //                        rf_we, csr_we, int_taken, mret_exec, illegal}
  localparam logic [12:0] Z    = 13'h0000;
  localparam logic [12:0] PCW  = 13'h1000;
  localparam logic [12:0] IMRD = 13'h0100;
  localparam logic [12:0] IRLD = 13'h0080;
  localparam logic [12:0] DRD  = 13'h0040;
  localparam logic [12:0] DWR  = 13'h0020;
  localparam logic [12:0] RF   = 13'h0010;
  localparam logic [12:0] CSR  = 13'h0008;
  localparam logic [12:0] INTK = 13'h0004;
  localparam logic [12:0] MRT  = 13'h0002;
  localparam logic [12:0] ILL  = 13'h0001;

  function automatic logic [12:0] sel(input int s);
    return 13'(s) << 9;
  endfunction

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_err = 0;

  otter_cu_fsm_if bus ();

  otter_cu_fsm #(.INIT_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .cu  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] act_vec();
    return {bus.pc_w_en, bus.pc_src_sel, bus.imem_rd, bus.ir_ld, bus.dmem_rd,
            bus.dmem_wr, bus.rf_we, bus.csr_we, bus.int_taken, bus.mret_exec,
            bus.illegal};
  endfunction

  // Compare mid-cycle, then advance to just after the next rising edge
  task automatic check(input string name, input logic [12:0] exp);
    #2;
    n_checks++;
    if (act_vec() !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act_vec(), exp);
    end
    @(posedge clk);
    #1;
  endtask

  // Reset held for n cycles, then INIT (4 quiet cycles), then first fetch request
  task automatic reset_seq(input int n);
    rst = 1'b1;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    for (int i = 0; i < n; i++) check("rst_zero", Z);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) check("init_zero", Z);
    check("first_fetch", IMRD);
  endtask

  // Behavioural model: run one instruction from FETCH to the next FETCH.
  // a/b are the register operands; flags are derived from them.
  task automatic do_instr(input string name, input logic [31:0] ir,
                          input logic [31:0] a, input logic [31:0] b,
                          input int ilat, input int dlat,
                          input logic intr_v, input logic mie_v);
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [12:0] e;
    bit          taken;
    bit          bad;
    op = ir[6:0];
    f3 = ir[14:12];
    bus.ir = ir;
    bus.br_eq  = (a == b);
    bus.br_lt  = ($signed(a) < $signed(b));
    bus.br_ltu = (a < b);
    bus.intr = intr_v;
    bus.mie  = mie_v;
    bus.dmem_ready = 1'b0;
    bus.imem_ready = 1'b0;
    for (int i = 0; i < ilat; i++) check({name, "_fwait"}, IMRD);
    bus.imem_ready = 1'b1;
    check({name, "_fetch"}, IMRD | IRLD);
    bus.imem_ready = 1'b0;
    case (op)
      7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: check(name, PCW | RF);
      7'b1101111: check(name, PCW | sel(3) | RF);
      7'b1100111: check(name, PCW | sel(1) | RF);
      7'b1100011: begin
        bad = 1'b0;
        case (f3)
          3'd0: taken = (a == b);
          3'd1: taken = (a != b);
          3'd4: taken = ($signed(a) <  $signed(b));
          3'd5: taken = ($signed(a) >= $signed(b));
          3'd6: taken = (a <  b);
          3'd7: taken = (a >= b);
          default: begin taken = 1'b0; bad = 1'b1; end
        endcase
        e = PCW | (taken ? sel(2) : Z) | (bad ? ILL : Z);
        check(name, e);
      end
      7'b0100011: begin
        for (int i = 0; i < dlat; i++) check({name, "_swait"}, DWR);
        bus.dmem_ready = 1'b1;
        check({name, "_sdone"}, PCW | DWR);
        bus.dmem_ready = 1'b0;
      end
      7'b0000011: begin
        for (int i = 0; i < dlat; i++) check({name, "_lwait"}, DRD);
        bus.dmem_ready = 1'b1;
        check({name, "_ldone"}, DRD);
        bus.dmem_ready = 1'b0;
        check({name, "_wb"}, PCW | RF);
      end
      7'b1110011: begin
        if (f3 != 3'd0) check(name, PCW | RF | CSR);
        else if (ir[31:20] == 12'h302) check(name, PCW | sel(5) | MRT);
        else check(name, PCW | ILL);
      end
      default: check(name, PCW | ILL);
    endcase
    if (intr_v && mie_v) check({name, "_trap"}, PCW | sel(4) | INTK);
  endtask

  typedef struct {
    string       name;
    logic [31:0] ir;
    logic        eq, lt, ltu, intr, mie;
    logic [12:0] exp;
    logic        trap;
  } vec_t;

  vec_t tbl[14];

  localparam logic [6:0] RND_OPS [11] = '{
    7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
    7'b1100011, 7'b0000011, 7'b0100011, 7'b1110011, 7'b0001111
  };

  initial begin
    tbl[0]  = '{"addi",       32'h00100093, 0, 0, 0, 0, 0, PCW | RF,                 0};
    tbl[1]  = '{"bne_taken",  32'h00209463, 0, 0, 0, 0, 0, PCW | sel(2),             0};
    tbl[2]  = '{"bne_not",    32'h00209463, 1, 0, 0, 0, 0, PCW,                      0};
    tbl[3]  = '{"bgeu_not",   32'h0020F463, 0, 0, 1, 0, 0, PCW,                      0};
    tbl[4]  = '{"br_f3_010",  32'h0020A463, 1, 0, 0, 0, 0, PCW | ILL,                0};
    tbl[5]  = '{"add_trap",   32'h002081B3, 0, 0, 0, 1, 1, PCW | RF,                 1};
    tbl[6]  = '{"add_nomie",  32'h002081B3, 0, 0, 0, 1, 0, PCW | RF,                 0};
    tbl[7]  = '{"jal",        32'h0080006F, 0, 0, 0, 0, 0, PCW | sel(3) | RF,        0};
    tbl[8]  = '{"jalr",       32'h000080E7, 0, 0, 0, 0, 0, PCW | sel(1) | RF,        0};
    tbl[9]  = '{"csrrw",      32'h30029073, 0, 0, 0, 0, 0, PCW | RF | CSR,           0};
    tbl[10] = '{"ecall",      32'h00000073, 0, 0, 0, 0, 0, PCW | ILL,                0};
    tbl[11] = '{"mret",       32'h30200073, 0, 0, 0, 0, 0, PCW | sel(5) | MRT,       0};
    tbl[12] = '{"mret_trap",  32'h30200073, 0, 0, 0, 1, 1, PCW | sel(5) | MRT,       1};
    tbl[13] = '{"beq_taken",  32'h00208463, 1, 0, 0, 0, 0, PCW | sel(2),             0};

    bus.ir = 32'h0; bus.br_eq = 1'b0; bus.br_lt = 1'b0; bus.br_ltu = 1'b0;
    bus.intr = 1'b0; bus.mie = 1'b0; bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;
    @(posedge clk);
    #1;

    reset_seq(3);

    // Directed vector table, one-cycle fetch each
    for (int i = 0; i < 14; i++) begin
      bus.ir = tbl[i].ir;
      bus.br_eq = tbl[i].eq; bus.br_lt = tbl[i].lt; bus.br_ltu = tbl[i].ltu;
      bus.intr = tbl[i].intr; bus.mie = tbl[i].mie;
      bus.imem_ready = 1'b1;
      check({tbl[i].name, "_fetch"}, IMRD | IRLD);
      bus.imem_ready = 1'b0;
      check(tbl[i].name, tbl[i].exp);
      if (tbl[i].trap) check({tbl[i].name, "_trap"}, PCW | sel(4) | INTK);
    end
    bus.intr = 1'b0;
    bus.mie = 1'b0;

    // Multi-cycle memory sequences; interrupt pending while waiting must not preempt
    do_instr("lw_lat3",  32'h0000A083, 32'h0, 32'h0, 0, 3, 1'b0, 1'b0);
    do_instr("sw_lat2",  32'h0010A023, 32'h0, 32'h0, 1, 2, 1'b0, 1'b0);
    do_instr("lw_intr",  32'h0000A083, 32'h0, 32'h0, 0, 2, 1'b1, 1'b1);
    do_instr("sw_intr",  32'h0010A023, 32'h0, 32'h0, 2, 1, 1'b1, 1'b1);

    // Reset while a store waits on memory
    bus.intr = 1'b0;
    bus.ir = 32'h0010A023;
    bus.imem_ready = 1'b1;
    check("rst_sw_fetch", IMRD | IRLD);
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    check("rst_sw_wait", DWR);
    reset_seq(1);

    // Randomized instructions against the model
    for (int k = 0; k < 200; k++) begin
      logic [31:0] rir;
      logic [31:0] ra, rb;
      int          ai, bi;
      rir = $urandom;
      rir[6:0] = RND_OPS[$urandom_range(0, 10)];
      if (rir[6:0] == 7'b1110011 && $urandom_range(0, 2) == 0) rir = 32'h30200073;
      ai = $urandom_range(0, 3);
      bi = $urandom_range(0, 3);
      ra = 32'(ai - 2);
      rb = 32'(bi - 2);
      do_instr("rnd", rir, ra, rb, $urandom_range(0, 2), $urandom_range(0, 3),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
